// File: rtl/tile_spawner.sv
// rtl/tile_spawner.sv - 2048 tile spawner: LFSR start pointer, circular scan for an empty cell
// Optional macro SPAWN_FOUR_EN enables the 1/16 chance of spawning exponent 2.
module tile_spawner (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] board_in,
    input  logic        seed_load,
    input  logic [15:0] seed,
    output logic        busy,
    output logic        done,
    output logic        full,
    output logic        spawned,
    output logic [3:0]  spawn_idx,
    output logic [63:0] board_out
);
    typedef enum logic {IDLE, SCAN} state_t;

    state_t      state;
    logic [15:0] lfsr;
    logic [63:0] board_q;
    logic [3:0]  ptr;
    logic [3:0]  val;
    logic [3:0]  new_val;
    logic        any_empty;
    logic        cell_empty;
    logic [63:0] placed;

    always_comb begin
        any_empty = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (board_in[i*4 +: 4] == 4'h0) any_empty = 1'b1;
        end
    end

`ifdef SPAWN_FOUR_EN
    assign new_val = (lfsr[7:4] == 4'h0) ? 4'h2 : 4'h1;
`else
    assign new_val = 4'h1;
`endif

    assign cell_empty = (board_q[{ptr, 2'b00} +: 4] == 4'h0);

    always_comb begin
        placed = board_q;
        placed[{ptr, 2'b00} +: 4] = val;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else if (seed_load) begin
            lfsr <= (seed == 16'h0000) ? 16'hACE1 : seed;
        end else begin
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            board_q   <= 64'h0;
            ptr       <= 4'h0;
            val       <= 4'h1;
            busy      <= 1'b0;
            done      <= 1'b0;
            full      <= 1'b0;
            spawned   <= 1'b0;
            spawn_idx <= 4'h0;
            board_out <= 64'h0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        board_q <= board_in;
                        ptr     <= lfsr[3:0];
                        val     <= new_val;
                        if (!any_empty) begin
                            // Nothing to place: complete immediately without entering SCAN.
                            board_out <= board_in;
                            full      <= 1'b1;
                            spawned   <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            state <= SCAN;
                            busy  <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (cell_empty) begin
                        board_out <= placed;
                        spawn_idx <= ptr;
                        spawned   <= 1'b1;
                        full      <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        ptr <= ptr + 4'h1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tile_spawner.sv
// tb/tb_tile_spawner.sv - table-driven bench for tile_spawner
module tb_tile_spawner;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] board_in;
    logic        seed_load;
    logic [15:0] seed;
    logic        busy;
    logic        done;
    logic        full;
    logic        spawned;
    logic [3:0]  spawn_idx;
    logic [63:0] board_out;

    tile_spawner dut (
        .clk(clk), .rst(rst), .start(start), .board_in(board_in),
        .seed_load(seed_load), .seed(seed), .busy(busy), .done(done),
        .full(full), .spawned(spawned), .spawn_idx(spawn_idx), .board_out(board_out)
    );

    always #5 clk = ~clk;

`ifdef SPAWN_FOUR_EN
    localparam logic [63:0] FOUR_VAL = 64'h2;
`else
    localparam logic [63:0] FOUR_VAL = 64'h1;
`endif

    typedef struct {
        string       name;
        logic [15:0] seed;
        logic [63:0] bin;
        logic [63:0] bout;
        logic        full;
        logic [3:0]  idx;
        int          lat;
        int          busy_n;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic run_req(input logic [15:0] s, input logic [63:0] b, output int lat, output int bcnt);
        seed = s;
        seed_load = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0;
        board_in = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        board_in = '1;
        lat = -1;
        bcnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    vec_t vecs[6];
    int lat, bcnt, ndone;

    initial begin
        // ACE1 seed substitution for 0: ptr=1, lfsr[7:4]=E
        vecs[0] = '{"full_board", 16'h1234, 64'h3333_3333_3333_3333, 64'h3333_3333_3333_3333, 1'b1, 4'h0, 1, 0};
        vecs[1] = '{"empty_seed1234", 16'h1234, 64'h0, 64'h0000_0000_0001_0000, 1'b0, 4'h4, 2, 1};
        vecs[2] = '{"wrap_cell2", 16'h0015, 64'h1111_1111_1111_1011, 64'h1111_1111_1111_1111, 1'b0, 4'h2, 15, 14};
        vecs[3] = '{"four_tile", 16'h0007, 64'h0, FOUR_VAL << 28, 1'b0, 4'h7, 2, 1};
        vecs[4] = '{"zero_seed", 16'h0000, 64'h0000_0000_0000_0555, 64'h0000_0000_0000_1555, 1'b0, 4'h3, 4, 3};
        vecs[5] = '{"wrap_15_to_0", 16'h00FF, 64'h2222_2222_2222_2220, 64'h2222_2222_2222_2221, 1'b0, 4'h0, 3, 2};

        rst = 1'b1;
        start = 1'b0;
        board_in = 64'h0;
        seed_load = 1'b0;
        seed = 16'h0;
        #12;
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_done", {63'h0, done}, 64'h0);
        check("rst_board_out", board_out, 64'h0);
        check("rst_spawn_idx", {60'h0, spawn_idx}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_req(vecs[i].seed, vecs[i].bin, lat, bcnt);
            check({vecs[i].name, "_latency"}, lat, vecs[i].lat);
            check({vecs[i].name, "_busy_cycles"}, bcnt, vecs[i].busy_n);
            check({vecs[i].name, "_full"}, {63'h0, full}, {63'h0, vecs[i].full});
            check({vecs[i].name, "_spawned"}, {63'h0, spawned}, {63'h0, ~vecs[i].full});
            check({vecs[i].name, "_spawn_idx"}, {60'h0, spawn_idx}, {60'h0, vecs[i].idx});
            check({vecs[i].name, "_board_out"}, board_out, vecs[i].bout);
        end

        // Extra start during SCAN must be ignored: exactly one done.
        seed = 16'h0015;
        seed_load = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0;
        board_in = 64'h1111_1111_1111_1011;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        board_in = 64'h0;
        ndone = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 3 || c == 7) start = 1'b1;
            @(negedge clk);
            if (done) ndone++;
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("busy_ignore_done_count", ndone, 1);
        check("busy_ignore_spawn_idx", {60'h0, spawn_idx}, 64'h2);
        check("busy_ignore_board_out", board_out, 64'h1111_1111_1111_1111);

        // Asynchronous reset in scan cycle 3 aborts the request.
        seed = 16'h0015;
        seed_load = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0;
        board_in = 64'h1111_1111_1111_1011;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_busy_before_rst", {63'h0, busy}, 64'h1);
        rst = 1'b1;
        #1;
        check("abort_busy", {63'h0, busy}, 64'h0);
        check("abort_board_out", board_out, 64'h0);
        check("abort_spawned", {63'h0, spawned}, 64'h0);
        check("abort_spawn_idx", {60'h0, spawn_idx}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("abort_no_done", ndone, 0);
        check("abort_board_out_after", board_out, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
